video_tx: RTL

- Transmit end of the video path: generates the raster (hs/vs/de) from counters and pulls 24-bit pixels from an upstream valid/ready stream, one beat per active pixel.
- Mirror of the input-side cursor/processing chain. Sits between the output pixel FIFO (processed frame data, SOF-tagged) and the video encoder pins.
- Enforces frame alignment via SOF, and blanks plus flags on underflow.

---
 rtl/video_pkg.sv | 25 ++
 rtl/raster_gen.sv | 70 +++++++
 rtl/video_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video types and default 1080p timing for the transmit path.
package video_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitSof,
        StRun
    } tx_state_e;

    localparam int unsigned H_WIDTH_1080P    = 1920;
    localparam int unsigned H_START_1080P    = 2008;
    localparam int unsigned H_SYNC_END_1080P = 2052;
    localparam int unsigned H_TOTAL_1080P    = 2200;
    localparam int unsigned V_HEIGHT_1080P   = 1080;
    localparam int unsigned V_START_1080P    = 1084;
    localparam int unsigned V_SYNC_END_1080P = 1089;
    localparam int unsigned V_TOTAL_1080P    = 1125;

    function automatic int unsigned cnt_w(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/raster_gen.sv
// Raster h/v counters with active-area, sync-window and end-of-frame qualifiers.
module raster_gen
    import video_pkg::*;
#(
    parameter int unsigned H_WIDTH    = H_WIDTH_1080P,
    parameter int unsigned H_START    = H_START_1080P,
    parameter int unsigned H_SYNC_END = H_SYNC_END_1080P,
    parameter int unsigned H_TOTAL    = H_TOTAL_1080P,
    parameter int unsigned V_HEIGHT   = V_HEIGHT_1080P,
    parameter int unsigned V_START    = V_START_1080P,
    parameter int unsigned V_SYNC_END = V_SYNC_END_1080P,
    parameter int unsigned V_TOTAL    = V_TOTAL_1080P
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic act_o,
    output logic hs_a_o,
    output logic vs_a_o,
    output logic origin_o,
    output logic eof_o
);
    localparam int unsigned HW = cnt_w(H_TOTAL);
    localparam int unsigned VW = cnt_w(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h, v;
    logic          h_end, v_end;

    // Compare in 32 bits so timing values near the counter limit never truncate.
    assign h     = 32'(h_q);
    assign v     = 32'(v_q);
    assign h_end = (h == H_TOTAL - 1);
    assign v_end = (v == V_TOTAL - 1);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (clr_i) begin
            h_d = '0;
            v_d = '0;
        end else if (en_i) begin
            if (h_end) begin
                h_d = '0;
                v_d = v_end ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign act_o    = (h < H_WIDTH) && (v < V_HEIGHT);
    assign hs_a_o   = (h >= H_START) && (h < H_SYNC_END);
    assign vs_a_o   = (v >= V_START) && (v < V_SYNC_END);
    assign origin_o = (h_q == '0) && (v_q == '0);
    assign eof_o    = h_end && v_end;

endmodule

// File: rtl/video_tx.sv
// Video transmit: raster generation, SOF-aligned pixel pull and underflow/resync flags.
// Define VIDEO_TX_UNDERFLOW_REPEAT_EN to repeat the last consumed pixel on underflow.
module video_tx
    import video_pkg::*;
#(
    parameter int unsigned H_WIDTH    = H_WIDTH_1080P,
    parameter int unsigned H_START    = H_START_1080P,
    parameter int unsigned H_SYNC_END = H_SYNC_END_1080P,
    parameter int unsigned H_TOTAL    = H_TOTAL_1080P,
    parameter int unsigned V_HEIGHT   = V_HEIGHT_1080P,
    parameter int unsigned V_START    = V_START_1080P,
    parameter int unsigned V_SYNC_END = V_SYNC_END_1080P,
    parameter int unsigned V_TOTAL    = V_TOTAL_1080P,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        pix_valid_i,
    input  logic        pix_sof_i,
    input  logic [23:0] pix_data_i,
    output logic        pix_ready_o,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic        vout_de_o,
    output logic [23:0] vout_data_o,
    output logic        frame_start_o,
    output logic        underflow_o,
    output logic        resync_o,
    input  logic        clr_i
);
    tx_state_e state_q, state_d;
    logic      run, act, hs_a, vs_a, origin, eof;
    logic      run_act, pix_ok, uf_set, rs_set;
    logic      hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic      uf_q, uf_d, rs_q, rs_d;
    pixel_t    data_q, data_d;

    assign run     = en_i && (state_q != StIdle);
    assign run_act = run && (state_q == StRun) && act;
    // A beat is displayed only when its SOF tag matches the raster origin.
    assign pix_ok  = run_act && pix_valid_i && (pix_sof_i == origin);
    assign uf_set  = run_act && !pix_valid_i;
    assign rs_set  = run_act && pix_valid_i && (pix_sof_i != origin);

    raster_gen #(
        .H_WIDTH    (H_WIDTH),
        .H_START    (H_START),
        .H_SYNC_END (H_SYNC_END),
        .H_TOTAL    (H_TOTAL),
        .V_HEIGHT   (V_HEIGHT),
        .V_START    (V_START),
        .V_SYNC_END (V_SYNC_END),
        .V_TOTAL    (V_TOTAL)
    ) u_raster (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (run),
        .clr_i    (!run),
        .act_o    (act),
        .hs_a_o   (hs_a),
        .vs_a_o   (vs_a),
        .origin_o (origin),
        .eof_o    (eof)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    state_d = StWaitSof;
                StWaitSof: if (eof && pix_valid_i && pix_sof_i) state_d = StRun;
                StRun:     if (rs_set) state_d = StWaitSof;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pix_ready_o = 1'b0;
        if (en_i && !rst_i) begin
            case (state_q)
                StWaitSof: pix_ready_o = pix_valid_i && !pix_sof_i;
                StRun:     pix_ready_o = act && !(pix_sof_i && !origin);
                default:   pix_ready_o = 1'b0;
            endcase
        end
    end

`ifdef VIDEO_TX_UNDERFLOW_REPEAT_EN
    pixel_t hold_q, hold_d;

    assign hold_d = pix_ok ? pix_data_i : hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`endif

    always_comb begin
        hs_d   = ~HS_POL;
        vs_d   = ~VS_POL;
        de_d   = 1'b0;
        fs_d   = 1'b0;
        data_d = '0;
        if (run) begin
            hs_d = hs_a ? HS_POL : ~HS_POL;
            vs_d = vs_a ? VS_POL : ~VS_POL;
            de_d = act;
            fs_d = (state_q == StRun) && origin;
            if (pix_ok) data_d = pix_data_i;
`ifdef VIDEO_TX_UNDERFLOW_REPEAT_EN
            else if (uf_set) data_d = hold_q;
`endif
        end
    end

    // Set beats clear when both land in the same cycle.
    assign uf_d = uf_set || (uf_q && !clr_i);
    assign rs_d = rs_set || (rs_q && !clr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            data_q <= '0;
            uf_q   <= 1'b0;
            rs_q   <= 1'b0;
        end else begin
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            fs_q   <= fs_d;
            data_q <= data_d;
            uf_q   <= uf_d;
            rs_q   <= rs_d;
        end
    end

    assign vout_hs_o     = hs_q;
    assign vout_vs_o     = vs_q;
    assign vout_de_o     = de_q;
    assign vout_data_o   = data_q;
    assign frame_start_o = fs_q;
    assign underflow_o   = uf_q;
    assign resync_o      = rs_q;

endmodule
